// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth calculation, pointer difference
// and threshold compares, reused by the FIFO variants.
package fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Occupancy from wrap-extended pointers, modulo 2**(aw+1).
    function automatic int unsigned ptr_diff(
        input int unsigned wp,
        input int unsigned rp,
        input int unsigned aw
    );
        return (wp - rp) & ((32'd1 << (aw + 1)) - 32'd1);
    endfunction

    function automatic logic at_least(
        input int unsigned cnt,
        input int unsigned th
    );
        return cnt >= th;
    endfunction

    function automatic logic at_most(
        input int unsigned cnt,
        input int unsigned th
    );
        return cnt <= th;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy, threshold and sticky error flags,
// selectable standard or first-word-fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = int'(fifo_depth(ADDR_WIDTH)) - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_cnt,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int          CW    = ADDR_WIDTH + 1;

    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [CW-1:0]         w_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_cnt    = CW'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr),
                                   ADDR_WIDTH));
    assign w_full   = (w_cnt == CW'(DEPTH));
    assign w_empty  = (w_cnt == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    assign fifo_cnt     = w_cnt;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = at_least(32'(w_cnt), AFULL_TH);
    assign almost_empty = at_most(32'(w_cnt), AEMPTY_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (clk),
        .i_we   (w_wr_acc),
        .i_waddr(r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata(wr_data),
        .i_raddr(r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata(w_mem_rdata)
    );

    // Pointer advance on accepted writes and reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky errors: a new error wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow && !err_clr) || (wr_en && w_full);
            r_underflow <= (r_underflow && !err_clr) || (rd_en && w_empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = w_mem_rdata;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // Registered read: capture head word on an accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= w_mem_rdata;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-read instance plus a FWFT instance,
// both DEPTH=4, AFULL_TH=3, AEMPTY_TH=1.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       wr_en = 0, rd_en = 0, err_clr = 0;
    logic [7:0] wr_data = 0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, afull, aempty, ovf, unf;
    logic [2:0] cnt;

    logic       f_wr_en = 0, f_rd_en = 0, f_err_clr = 0;
    logic [7:0] f_wr_data = 0;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty;
    logic       f_ovf, f_unf;
    logic [2:0] f_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0),
        .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(afull), .almost_empty(aempty),
        .fifo_cnt(cnt), .overflow(ovf), .underflow(unf),
        .err_clr(err_clr)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1),
        .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut_f (
        .clk(clk), .rst(rst),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty),
        .fifo_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf),
        .err_clr(f_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic [7:0] d,
                       input logic r, input logic c);
        wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    endtask

    initial begin
        #12;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_errs", {30'd0, ovf, unf}, 0);
        rst = 1'b0;
        tick();

        // Fill to full, then one dropped write.
        drv(1, 8'h11, 0, 0); tick();
        chk("w1_cnt", 32'(cnt), 1);
        chk("w1_aempty", 32'(aempty), 1);
        drv(1, 8'h22, 0, 0); tick();
        chk("w2_cnt", 32'(cnt), 2);
        chk("w2_flags", {28'd0, afull, aempty, full, empty}, 0);
        drv(1, 8'h33, 0, 0); tick();
        chk("w3_cnt", 32'(cnt), 3);
        chk("w3_afull", 32'(afull), 1);
        chk("w3_full", 32'(full), 0);
        drv(1, 8'h44, 0, 0); tick();
        chk("w4_cnt", 32'(cnt), 4);
        chk("w4_full", 32'(full), 1);
        chk("w4_ovf", 32'(ovf), 0);
        drv(1, 8'h55, 0, 0); tick();
        chk("w5_cnt", 32'(cnt), 4);
        chk("w5_ovf", 32'(ovf), 1);

        // Drain in order, then an extra read.
        drv(0, 0, 1, 0); tick();
        chk("r1_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h11});
        chk("r1_cnt", 32'(cnt), 3);
        tick();
        chk("r2_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h22});
        tick();
        chk("r3_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h33});
        tick();
        chk("r4_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h44});
        chk("r4_empty", {30'd0, empty, full}, 2);
        chk("r4_unf", 32'(unf), 0);
        tick();
        chk("r5_valid", 32'(rd_valid), 0);
        chk("r5_hold", 32'(rd_data), 8'h44);
        chk("r5_errs", {30'd0, ovf, unf}, 3);
        drv(0, 0, 0, 1); tick();
        chk("clr_errs", {30'd0, ovf, unf}, 0);

        // Error wins over same-cycle clear.
        drv(0, 0, 1, 1); tick();
        chk("clr_vs_err", 32'(unf), 1);
        drv(0, 0, 0, 1); tick();

        // Full with both enables: read wins, write rejected.
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'hA0 + 8'(i), 0, 0); tick();
        end
        chk("fill_full", 32'(full), 1);
        drv(1, 8'hEE, 1, 0); tick();
        chk("fb_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'hA0});
        chk("fb_cnt", 32'(cnt), 3);
        chk("fb_ovf", 32'(ovf), 1);
        drv(0, 0, 1, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("fb_drain", 32'(rd_data), 32'(8'hA0 + 8'(i)));
        end
        chk("fb_empty", 32'(empty), 1);
        drv(0, 0, 0, 1); tick();

        // Empty with both enables: write wins, no read data.
        drv(1, 8'h77, 1, 0); tick();
        chk("eb_cnt", 32'(cnt), 1);
        chk("eb_valid", 32'(rd_valid), 0);
        chk("eb_unf", 32'(unf), 1);
        drv(0, 0, 1, 0); tick();
        chk("eb_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h77});

        // Streaming at cnt 2 across several pointer wraps.
        drv(1, 8'h00, 0, 0); tick();
        drv(1, 8'h01, 0, 0); tick();
        for (int i = 2; i < 10; i++) begin
            drv(1, 8'(i), 1, 0); tick();
            chk("st_data", {23'd0, rd_valid, rd_data}, 32'(256 + i - 2));
            chk("st_cnt", 32'(cnt), 2);
        end
        drv(0, 0, 1, 0); tick();
        chk("st_d8", 32'(rd_data), 8'h08);
        tick();
        chk("st_d9", 32'(rd_data), 8'h09);
        chk("st_empty", 32'(empty), 1);
        drv(0, 0, 0, 0); tick();

        // FWFT: head word visible without rd_en.
        f_wr_en = 1; f_wr_data = 8'hA5; tick();
        f_wr_en = 0;
        chk("fw_valid", 32'(f_rd_valid), 1);
        chk("fw_data", 32'(f_rd_data), 8'hA5);
        tick();
        chk("fw_hold", {23'd0, f_rd_valid, f_rd_data}, {23'd0, 1'b1, 8'hA5});
        f_wr_en = 1; f_wr_data = 8'h3C; tick();
        f_wr_en = 0; f_rd_en = 1; tick();
        chk("fw_next", {23'd0, f_rd_valid, f_rd_data}, {23'd0, 1'b1, 8'h3C});
        tick();
        f_rd_en = 0;
        chk("fw_empty", {30'd0, f_empty, f_rd_valid}, 2);

        // Asynchronous reset mid-stream at cnt 3.
        drv(0, 0, 1, 0); tick();
        chk("pre_unf", 32'(unf), 1);
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'hC0 + 8'(i), 0, 0); tick();
        end
        drv(0, 0, 1, 0); tick();
        drv(0, 0, 0, 0);
        chk("pre_cnt", 32'(cnt), 3);
        chk("pre_valid", 32'(rd_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cnt", 32'(cnt), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_valid", 32'(rd_valid), 0);
        chk("ar_flags", {29'd0, ovf, unf, full}, 0);
        tick();
        rst = 1'b0;
        drv(1, 8'h5A, 0, 0); tick();
        chk("ar_wcnt", 32'(cnt), 1);
        drv(0, 0, 1, 0); tick();
        chk("ar_data", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h5A});
        chk("ar_end", 32'(empty), 1);
        drv(0, 0, 0, 0); tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2: almost_full threshold in words.
REQ-005 SHALL have parameter AEMPTY_TH, default 2: almost_empty threshold in words.
REQ-006 SHALL have clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have rst  in  1  reset, asynchronous and active-high.
REQ-008 SHALL have wr_en  in  1  write request.
REQ-009 SHALL have wr_data  in  DATA_WIDTH  write word.
REQ-010 SHALL have rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
REQ-011 SHALL have rd_data  out  DATA_WIDTH  read word.
REQ-012 SHALL have rd_valid  out  1  rd_data qualifier.
REQ-013 SHALL have full, empty  out  1 each  occupancy flags.
REQ-014 SHALL have almost_full, almost_empty  out  1 each  threshold flags.
REQ-015 SHALL have fifo_cnt  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have overflow, underflow  out  1 each  sticky error flags.
REQ-017 SHALL have err_clr  in  1  synchronous clear of both sticky error flags.

Function
REQ-018 SHALL use ADDR_WIDTH+1-bit write and read pointers; the MSB distinguishes wrap; fifo_cnt = wr_ptr - rd_ptr (modulo 2**(ADDR_WIDTH+1)).
REQ-019 SHALL derive full = (fifo_cnt == DEPTH) and empty = (fifo_cnt == 0), both from current registered state only, with no look-ahead on wr_en/rd_en.
REQ-020 SHALL derive almost_full = (fifo_cnt >= AFULL_TH) and almost_empty = (fifo_cnt <= AEMPTY_TH), combinationally from fifo_cnt.
REQ-021 SHALL accept a write only when wr_en && !full: store wr_data at wr_ptr, then increment wr_ptr.
REQ-022 SHALL accept a read only when rd_en && !empty, then increment rd_ptr.
REQ-023 Simultaneous accepted write and read SHALL leave fifo_cnt unchanged.
REQ-024 When full, a simultaneous read SHALL be accepted and the write SHALL be rejected; fifo_cnt SHALL become DEPTH-1.
REQ-025 When empty, a simultaneous write SHALL be accepted and the read SHALL be rejected; fifo_cnt SHALL become 1.
REQ-026 A write with wr_en && full SHALL set overflow; a read with rd_en && empty SHALL set underflow.
REQ-027 Sticky flags SHALL hold until err_clr; if err_clr and a new error occur in the same cycle, the flag SHALL remain set.
REQ-028 With FWFT=0, an accepted read SHALL register mem[rd_ptr] into rd_data with rd_valid=1 on the next cycle; otherwise rd_valid=0 and rd_data SHALL hold its value.
REQ-029 With FWFT=1, rd_data SHALL be mem[rd_ptr] combinationally and rd_valid = !empty; a written word SHALL appear one cycle after its write edge.
REQ-030 Pointer wrap from DEPTH-1 to 0 (low bits) SHALL be seamless, with no lost or duplicated words.

Reset
REQ-031 rst SHALL asynchronously clear wr_ptr, rd_ptr, rd_data, rd_valid, overflow and underflow to 0; empty=1, full=0, fifo_cnt=0.
REQ-032 Storage array contents SHALL NOT be reset; reset mid-operation SHALL discard all stored words.

Structure
REQ-033 DEPTH calculation and pointer-difference/flag-compare helpers SHALL live in a shared header/package (fifo_pkg) for reuse by later FIFO variants.
REQ-034 Storage SHALL be a separate sub-module sync_fifo_ram (one write port, asynchronous read port, DATA_WIDTH x DEPTH, no reset).

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-035 Write 0x11,0x22,0x33,0x44 on consecutive cycles, then one more write of 0x55 -> fifo_cnt 1,2,3,4; almost_full at cnt 3; full at cnt 4; 0x55 dropped; overflow=1.
REQ-036 From full, read 4 words with FWFT=0, then one more read -> rd_data 0x11..0x44, each valid one cycle after rd_en; empty at cnt 0; extra read sets underflow=1; err_clr clears both flags.
REQ-037 Full FIFO with wr_en=rd_en=1 -> head word read out, write rejected, fifo_cnt=3, overflow=1; empty FIFO with both asserted -> write accepted, no read data, fifo_cnt=1, underflow=1.
REQ-038 Stream 10 words 0x00..0x09 with continuous concurrent writes and reads at cnt 2 -> output order 0x00..0x09, fifo_cnt constant at 2, pointers wrap twice.
REQ-039 FWFT=1: write 0xA5 into empty FIFO -> next cycle rd_valid=1, rd_data=0xA5 without rd_en; rd_en -> empty=1, rd_valid=0.
REQ-040 Assert rst mid-stream at cnt 3 -> immediately fifo_cnt=0, empty=1, rd_valid=0, flags 0; next write/read returns the new word only.
